// File: rtl/scan_ctrl_pkg.sv
// Shared encodings for the scan chain controller: FSM states and shift modes.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit index counter for a scan pass; terminal flags the last bit of the pass.
module scan_bit_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [LEN_W-1:0] len_q,
  output logic [LEN_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable)
      count <= count + LEN_W'(1);
  end

  assign terminal = (count == len_q - LEN_W'(1));

endmodule

// File: rtl/scan_chain_controller.sv
// Host-side scan initiator: shifts a latched image into a scan chain for len
// clocks while capturing the image shifted out of it.
module scan_chain_controller
  import scan_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] tx_data,
  output logic               busy,
  output logic               done,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               scan_enable,
  output logic               scan_in,
  input  logic               scan_out
);

  state_t             state, state_next;
  logic [MAX_LEN-1:0] tx_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_clamped;
  logic               mode_q;
  logic [LEN_W-1:0]   bit_idx;
  logic               terminal;
  logic               counter_clear;
  logic               counter_en;
  logic               accept;
  logic               tx_bit;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign accept      = (state == S_IDLE) && start;

  scan_bit_counter #(.LEN_W(LEN_W)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (counter_clear),
    .enable   (counter_en),
    .len_q    (len_q),
    .count    (bit_idx),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= '0;
      len_q  <= '0;
      mode_q <= MODE_LOAD;
    end else if (accept) begin
      tx_q   <= tx_data;
      len_q  <= len_clamped;
      mode_q <= mode;
    end
  end

  // Capture happens on the same edge the chain shifts, so rx_data[k] is the
  // chain's last-register value before shift k. Untouched bits hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= '0;
    end else if (state == S_SHIFT) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (bit_idx == LEN_W'(i))
          rx_data[i] <= scan_out;
      end
    end
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    done          = 1'b0;
    scan_enable   = 1'b0;
    counter_clear = 1'b0;
    counter_en    = 1'b0;
    case (state)
      S_IDLE: begin
        counter_clear = 1'b1;
        if (start)
          state_next = (len_clamped == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy        = 1'b1;
        scan_enable = 1'b1;
        counter_en  = 1'b1;
        if (terminal)
          state_next = S_DONE;
      end
      S_DONE: begin
        done          = 1'b1;
        counter_clear = 1'b1;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Rotate feeds the chain output straight back; scan_out comes from a chain
  // register, so this path has no combinational loop.
  always_comb begin
    tx_bit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (bit_idx == LEN_W'(i))
        tx_bit = tx_q[i];
    end
  end

  always_comb begin
    scan_in = 1'b0;
    if (state == S_SHIFT)
      scan_in = (mode_q == MODE_ROTATE) ? scan_out : tx_bit;
  end

endmodule
